// File: rtl/ctr_stream_cipher.sv
// Multi-lane counter-mode stream cipher: lane i of each accepted beat is XORed
// with sbox(cb + i); one registered output stage with valid/ready on both sides.

module ctr_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign y = SBOX[a];
endmodule

module ctr_stream_cipher #(
    parameter  int LANES = 4,
    localparam int CNT_W = $clog2(LANES + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           key,
    input  logic                 key_load,
    input  logic [8*LANES-1:0]   din_data,
    input  logic [CNT_W-1:0]     din_cnt,
    input  logic                 din_valid,
    output logic                 din_ready,
    output logic [8*LANES-1:0]   dout_data,
    output logic [CNT_W-1:0]     dout_cnt,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 keyed
);
    localparam logic [CNT_W-1:0] LANES_CNT = CNT_W'(LANES);

    typedef enum logic {UNKEYED, KEYED} state_t;

    state_t               state_reg, state_next;
    logic [7:0]           cb_reg, cb_next;
    logic [8*LANES-1:0]   dout_data_reg, lanes_next;
    logic [CNT_W-1:0]     dout_cnt_reg, cnt_clamped;
    logic                 dout_valid_reg;
    logic                 accept;

    assign din_ready   = (state_reg == KEYED) && (!dout_valid_reg || dout_ready);
    assign accept      = din_valid && din_ready;
    assign cnt_clamped = (din_cnt > LANES_CNT) ? LANES_CNT : din_cnt;

    // Unused lanes are forced to zero so they never leak keystream.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [7:0] ks;
        ctr_sbox u_sbox (
            .a (cb_reg + 8'(gi)),
            .y (ks)
        );
        assign lanes_next[8*gi +: 8] = (CNT_W'(gi) < cnt_clamped)
                                     ? (din_data[8*gi +: 8] ^ ks) : 8'h00;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= UNKEYED;
            cb_reg    <= 8'h00;
        end else begin
            state_reg <= state_next;
            cb_reg    <= cb_next;
        end
    end

    // A key load always overrides the post-accept counter advance.
    always_comb begin
        state_next = state_reg;
        cb_next    = cb_reg;
        case (state_reg)
            UNKEYED: begin
                if (key_load) begin
                    cb_next    = key;
                    state_next = KEYED;
                end
            end
            KEYED: begin
                if (accept)
                    cb_next = cb_reg + {{(8-CNT_W){1'b0}}, cnt_clamped};
                if (key_load)
                    cb_next = key;
            end
            default: state_next = UNKEYED;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_data_reg  <= '0;
            dout_cnt_reg   <= '0;
            dout_valid_reg <= 1'b0;
        end else if (accept) begin
            dout_data_reg  <= lanes_next;
            dout_cnt_reg   <= cnt_clamped;
            dout_valid_reg <= 1'b1;
        end else if (dout_ready) begin
            dout_valid_reg <= 1'b0;
        end
    end

    assign dout_data  = dout_data_reg;
    assign dout_cnt   = dout_cnt_reg;
    assign dout_valid = dout_valid_reg;
    assign keyed      = (state_reg == KEYED);
endmodule

// File: tb/tb_ctr_stream_cipher.sv
// Directed bench for ctr_stream_cipher (LANES=4): keying, wrap, partial beats,
// backpressure streaming, same-cycle re-key and asynchronous reset.

module tb_ctr_stream_cipher;
    localparam int LANES = 4;
    localparam int CNT_W = 3;

    localparam logic [7:0] SBOX_REF [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [7:0]           key = 8'h00;
    logic                 key_load = 1'b0;
    logic [8*LANES-1:0]   din_data = '0;
    logic [CNT_W-1:0]     din_cnt = '0;
    logic                 din_valid = 1'b0;
    logic                 din_ready;
    logic [8*LANES-1:0]   dout_data;
    logic [CNT_W-1:0]     dout_cnt;
    logic                 dout_valid;
    logic                 dout_ready = 1'b1;
    logic                 keyed;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ctr_stream_cipher #(.LANES(LANES)) dut (
        .clk        (clk),
        .rst        (rst),
        .key        (key),
        .key_load   (key_load),
        .din_data   (din_data),
        .din_cnt    (din_cnt),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout_data  (dout_data),
        .dout_cnt   (dout_cnt),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .keyed      (keyed)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: %0h", tag, got);
        end
    endtask

    function automatic logic [31:0] ks_word(input logic [7:0] cb);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) begin
            logic [7:0] idx;
            idx = cb + 8'(i);
            w[8*i +: 8] = SBOX_REF[idx];
        end
        return w;
    endfunction

    task automatic load_key(input logic [7:0] k);
        @(negedge clk);
        key      = k;
        key_load = 1'b1;
        @(negedge clk);
        key_load = 1'b0;
    endtask

    // One beat with the sink always ready; checks the registered result.
    task automatic beat(input string tag, input logic [31:0] data, input logic [2:0] cnt,
                        input logic [31:0] exp_data, input logic [2:0] exp_cnt);
        @(negedge clk);
        din_data   = data;
        din_cnt    = cnt;
        din_valid  = 1'b1;
        dout_ready = 1'b1;
        #1;
        check_eq({tag, " rdy"}, 64'(din_ready), 64'd1);
        @(negedge clk);
        din_valid = 1'b0;
        check_eq({tag, " vld"}, 64'(dout_valid), 64'd1);
        check_eq({tag, " data"}, 64'(dout_data), 64'(exp_data));
        check_eq({tag, " cnt"}, 64'(dout_cnt), 64'(exp_cnt));
    endtask

    logic [31:0] stream_in  [8];
    logic [31:0] stream_exp [8];

    initial begin
        // 1: reset state and unkeyed behaviour
        #2;
        check_eq("rst keyed", 64'(keyed), 64'd0);
        check_eq("rst vld", 64'(dout_valid), 64'd0);
        check_eq("rst data", 64'(dout_data), 64'd0);
        @(negedge clk);
        rst       = 1'b0;
        din_valid = 1'b1;
        din_cnt   = 3'd4;
        repeat (3) begin
            @(negedge clk);
            check_eq("unkeyed rdy", 64'(din_ready), 64'd0);
            check_eq("unkeyed vld", 64'(dout_valid), 64'd0);
        end
        din_valid = 1'b0;
        load_key(8'h10);
        check_eq("keyed", 64'(keyed), 64'd1);

        // 2: counter wrap FE -> 02
        load_key(8'hFE);
        beat("wrap", 32'h03020100, 3'd4, 32'h7f6117bb, 3'd4);
        beat("cb02", 32'h00000000, 3'd1, 32'h00000077, 3'd1);

        // 3: partial and empty beats
        load_key(8'h20);
        beat("part3", 32'hAABBCCDD, 3'd3, 32'h0028316a, 3'd3);
        beat("cnt0", 32'h12345678, 3'd0, 32'h00000000, 3'd0);
        beat("cb23", 32'h00000000, 3'd4, 32'hf73f3626, 3'd4);

        // 4: streaming with dout_ready pattern 1,0,0 repeating
        load_key(8'h50);
        for (int k = 0; k < 8; k++) begin
            stream_in[k]  = 32'h0F1E2D3C ^ (32'(k) * 32'h11111111);
            stream_exp[k] = stream_in[k] ^ ks_word(8'h50 + 8'(4 * k));
        end
        begin
            int send_idx = 0;
            int recv_idx = 0;
            int cyc = 0;
            logic held = 1'b0;
            logic [31:0] held_data = '0;
            @(negedge clk);
            while (recv_idx < 8 && cyc < 200) begin
                dout_ready = (cyc % 3 == 0);
                din_valid  = (send_idx < 8);
                din_cnt    = 3'd4;
                din_data   = (send_idx < 8) ? stream_in[send_idx] : 32'h0;
                #1;
                if (dout_valid && held)
                    check_eq("stall hold", 64'(dout_data), 64'(held_data));
                if (dout_valid && dout_ready) begin
                    check_eq($sformatf("stream %0d", recv_idx), 64'(dout_data), 64'(stream_exp[recv_idx]));
                    recv_idx++;
                    held = 1'b0;
                end else if (dout_valid) begin
                    held      = 1'b1;
                    held_data = dout_data;
                end
                if (din_valid && din_ready)
                    send_idx++;
                cyc++;
                @(negedge clk);
            end
            check_eq("stream done", 64'(recv_idx), 64'd8);
            din_valid  = 1'b0;
            dout_ready = 1'b1;
            @(negedge clk);
            check_eq("stream nodup", 64'(dout_valid), 64'd0);
        end
        beat("cb70", 32'h00000000, 3'd4, 32'h8f40a351, 3'd4);

        // 5: key_load in the same cycle as an accept
        load_key(8'h40);
        @(negedge clk);
        din_data   = 32'h0;
        din_cnt    = 3'd4;
        din_valid  = 1'b1;
        key        = 8'h80;
        key_load   = 1'b1;
        dout_ready = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        key_load  = 1'b0;
        check_eq("rekey old cb", 64'(dout_data), 64'h1a2c8309);
        beat("rekey new cb", 32'h00000000, 3'd4, 32'hec130ccd, 3'd4);

        // 6: async reset while an output beat is held
        @(negedge clk);
        din_data   = 32'h0;
        din_cnt    = 3'd4;
        din_valid  = 1'b1;
        dout_ready = 1'b0;
        @(negedge clk);
        din_valid = 1'b0;
        check_eq("held vld", 64'(dout_valid), 64'd1);
        check_eq("held data", 64'(dout_data), 64'h1744975f);
        #2;
        rst        = 1'b1;
        dout_ready = 1'b1;
        #1;
        check_eq("arst vld", 64'(dout_valid), 64'd0);
        check_eq("arst keyed", 64'(keyed), 64'd0);
        check_eq("arst rdy", 64'(din_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("post rst rdy", 64'(din_ready), 64'd0);
        load_key(8'h00);
        beat("clamp7", 32'hFFFFFFFF, 3'd7, 32'h8488839c, 3'd4);
        beat("cb04", 32'h00000000, 3'd1, 32'h000000f2, 3'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
